// File: rtl/exe_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EXE.
// Stalls the pipeline front while iterating and pulses div_valid once per result.
module exe_div_unit #(
   parameter int DIV_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 div_start,
   input  logic                 div_signed,
   input  logic [DIV_WIDTH-1:0] div_opa,
   input  logic [DIV_WIDTH-1:0] div_opb,
   input  logic                 div_cancel,
   output logic                 div_stall,
   output logic                 div_busy,
   output logic                 div_valid,
   output logic [DIV_WIDTH-1:0] div_quotient,
   output logic [DIV_WIDTH-1:0] div_remainder
);

   localparam int CNT_W = $clog2(DIV_WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIVIDE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] rem_q, rem_d;
   logic [DIV_WIDTH-1:0] quo_q, quo_d;
   logic [DIV_WIDTH-1:0] dvsr_q, dvsr_d;
   logic                 sgn_q, sgn_d;
   logic                 sa_q, sa_d;
   logic                 sb_q, sb_d;
   logic [DIV_WIDTH-1:0] q_out_q, q_out_d;
   logic [DIV_WIDTH-1:0] r_out_q, r_out_d;

   logic                 opa_neg, opb_neg;
   logic [DIV_WIDTH-1:0] mag_a, mag_b;
   logic [DIV_WIDTH:0]   shifted, trial;
   logic                 trial_ge;
   logic [DIV_WIDTH-1:0] step_rem, step_quo, fix_quo, fix_rem;
   logic                 accept;

   assign opa_neg = div_signed & div_opa[DIV_WIDTH-1];
   assign opb_neg = div_signed & div_opb[DIV_WIDTH-1];
   assign mag_a   = opa_neg ? (~div_opa + 1'b1) : div_opa;
   assign mag_b   = opb_neg ? (~div_opb + 1'b1) : div_opb;

   // shifted < 2*divisor, so the W+1-bit difference never wraps and its MSB is the sign.
   assign shifted  = {rem_q, quo_q[DIV_WIDTH-1]};
   assign trial    = shifted - {1'b0, dvsr_q};
   assign trial_ge = ~trial[DIV_WIDTH];
   assign step_rem = trial_ge ? trial[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
   assign step_quo = {quo_q[DIV_WIDTH-2:0], trial_ge};
   assign fix_quo  = (sgn_q && (sa_q != sb_q)) ? (~step_quo + 1'b1) : step_quo;
   assign fix_rem  = (sgn_q && sa_q) ? (~step_rem + 1'b1) : step_rem;

   assign accept = (state_q == S_IDLE) && div_start && !div_cancel;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      sgn_d   = sgn_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      q_out_d = q_out_q;
      r_out_d = r_out_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               sgn_d  = div_signed;
               sa_d   = opa_neg;
               sb_d   = opb_neg;
               quo_d  = mag_a;
               dvsr_d = mag_b;
               rem_d  = '0;
               cnt_d  = CNT_W'(DIV_WIDTH);
               if (div_opb == '0) begin
                  q_out_d = '1;
                  r_out_d = div_opa;
                  state_d = S_DONE;
               end else begin
                  state_d = S_DIVIDE;
               end
            end
         end
         S_DIVIDE: begin
            if (div_cancel) begin
               state_d = S_IDLE;
            end else begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  q_out_d = fix_quo;
                  r_out_d = fix_rem;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         sgn_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         q_out_q <= '0;
         r_out_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         sgn_q   <= sgn_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         q_out_q <= q_out_d;
         r_out_q <= r_out_d;
      end
   end

   assign div_stall     = accept || (state_q == S_DIVIDE);
   assign div_busy      = (state_q == S_DIVIDE);
   assign div_valid     = (state_q == S_DONE);
   assign div_quotient  = q_out_q;
   assign div_remainder = r_out_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// Randomized and directed bench for exe_div_unit against an arithmetic reference model.
module tb_exe_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         div_start, div_signed, div_cancel;
   logic [W-1:0] div_opa, div_opb;
   logic         div_stall, div_busy, div_valid;
   logic [W-1:0] div_quotient, div_remainder;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   exe_div_unit #(.DIV_WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst_n),
      .div_start    (div_start),
      .div_signed   (div_signed),
      .div_opa      (div_opa),
      .div_opb      (div_opb),
      .div_cancel   (div_cancel),
      .div_stall    (div_stall),
      .div_busy     (div_busy),
      .div_valid    (div_valid),
      .div_quotient (div_quotient),
      .div_remainder(div_remainder)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: truncating division, remainder takes dividend sign, /0 gives all-ones and raw dividend.
   task automatic model_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] q, output logic [W-1:0] r);
      longint sa, sb;
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = W'(sa / sb);
         r  = W'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   // Called just after a rising edge with the DUT idle; returns just after the edge following div_valid.
   task automatic run_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit chain, output logic [W-1:0] q_obs, output logic [W-1:0] r_obs);
      logic [W-1:0] eq, er;
      int lat, exp_lat, k;
      bit stall_ok, busy_ok;
      model_div(sgn, a, b, eq, er);
      exp_lat    = (b == '0) ? 1 : W + 1;
      div_signed = sgn;
      div_opa    = a;
      div_opb    = b;
      div_start  = 1'b1;
      #1;
      chk("stall_accept", 64'(div_stall), 64'd1);
      chk("busy_accept", 64'(div_busy), 64'd0);
      lat = -1;
      stall_ok = 1'b1;
      busy_ok  = 1'b1;
      k = 1;
      @(posedge clk); #1;
      while (lat < 0 && k <= 100) begin
         if (div_valid) begin
            lat = k;
         end else begin
            if (!div_stall) stall_ok = 1'b0;
            if (!div_busy)  busy_ok  = 1'b0;
            div_opa    = $urandom;
            div_opb    = $urandom;
            div_signed = 1'($urandom);
            @(posedge clk); #1;
            k++;
         end
      end
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("stall_profile", 64'(stall_ok), 64'd1);
      chk("busy_profile", 64'(busy_ok), 64'd1);
      chk("stall_done", 64'(div_stall), 64'd0);
      chk("quotient", 64'(div_quotient), 64'(eq));
      chk("remainder", 64'(div_remainder), 64'(er));
      q_obs = div_quotient;
      r_obs = div_remainder;
      $display("div sgn=%0d a=0x%08h b=0x%08h -> q=0x%08h r=0x%08h lat=%0d (exp q=0x%08h r=0x%08h lat=%0d)",
               sgn, a, b, div_quotient, div_remainder, lat, eq, er, exp_lat);
      if (!chain) div_start = 1'b0;
      @(posedge clk); #1;
      chk("valid_pulse", 64'(div_valid), 64'd0);
   endtask

   initial begin
      logic [W-1:0] q, r, pq, pr, a, b;
      bit sgn;
      int seen;

      rst_n = 1'b0; div_start = 1'b0; div_signed = 1'b0; div_cancel = 1'b0;
      div_opa = '0; div_opb = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", 64'(div_stall), 64'd0);
      chk("rst_busy", 64'(div_busy), 64'd0);
      chk("rst_valid", 64'(div_valid), 64'd0);
      chk("rst_quo", 64'(div_quotient), 64'd0);
      chk("rst_rem", 64'(div_remainder), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_div(1'b0, 32'd100, 32'd7, 1'b0, q, r);
      chk("tp_divu_q", 64'(q), 64'h0000000E);
      chk("tp_divu_r", 64'(r), 64'h00000002);
      run_div(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, q, r);
      chk("tp_div_neg_q", 64'(q), 64'hFFFFFFFD);
      chk("tp_div_neg_r", 64'(r), 64'hFFFFFFFF);
      run_div(1'b0, 32'hFFFFFFF9, 32'd2, 1'b0, q, r);
      chk("tp_divu_big_q", 64'(q), 64'h7FFFFFFC);
      chk("tp_divu_big_r", 64'(r), 64'h00000001);
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, q, r);
      chk("tp_ovf_q", 64'(q), 64'h80000000);
      chk("tp_ovf_r", 64'(r), 64'h0);
      run_div(1'b0, 32'd5, 32'd0, 1'b0, q, r);
      chk("tp_dz_q", 64'(q), 64'hFFFFFFFF);
      chk("tp_dz_r", 64'(r), 64'h5);
      pq = q; pr = r;

      // cancel held in IDLE blocks acceptance
      div_start = 1'b1; div_cancel = 1'b1; div_opa = 32'd8; div_opb = 32'd2; div_signed = 1'b0;
      #1;
      chk("idle_cancel_stall", 64'(div_stall), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("idle_cancel_busy", 64'(div_busy), 64'd0);
      div_start = 1'b0; div_cancel = 1'b0;
      @(posedge clk); #1;

      // cancel mid-divide
      div_start = 1'b1; div_opa = 32'd1000; div_opb = 32'd3; div_signed = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("cancel_busy_before", 64'(div_busy), 64'd1);
      div_cancel = 1'b1;
      @(posedge clk); #1;
      div_cancel = 1'b0; div_start = 1'b0;
      #1;
      chk("cancel_stall_after", 64'(div_stall), 64'd0);
      chk("cancel_busy_after", 64'(div_busy), 64'd0);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (div_valid) seen++;
      end
      chk("cancel_no_valid", 64'(seen), 64'd0);
      chk("cancel_keep_q", 64'(div_quotient), 64'(pq));
      chk("cancel_keep_r", 64'(div_remainder), 64'(pr));
      $display("cancel 1000/3 at cycle 10: valid pulses=%0d q=0x%08h r=0x%08h", seen, div_quotient, div_remainder);

      // async reset mid-divide
      div_start = 1'b1; div_opa = 32'hFFFFFFF9; div_opb = 32'd2; div_signed = 1'b1;
      repeat (15) @(posedge clk);
      #4;
      rst_n = 1'b0; div_start = 1'b0;
      #1;
      chk("midrst_stall", 64'(div_stall), 64'd0);
      chk("midrst_busy", 64'(div_busy), 64'd0);
      chk("midrst_valid", 64'(div_valid), 64'd0);
      chk("midrst_quo", 64'(div_quotient), 64'd0);
      chk("midrst_rem", 64'(div_remainder), 64'd0);
      $display("async reset at cycle 15: q=0x%08h r=0x%08h busy=%0d", div_quotient, div_remainder, div_busy);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_div(1'b0, 32'd9, 32'd3, 1'b0, q, r);
      chk("post_rst_q", 64'(q), 64'd3);
      chk("post_rst_r", 64'(r), 64'd0);

      // back to back: second accepted in the IDLE cycle right after DONE
      run_div(1'b0, 32'd50, 32'd5, 1'b1, q, r);
      chk("b2b1_q", 64'(q), 64'd10);
      chk("b2b1_r", 64'(r), 64'd0);
      run_div(1'b0, 32'd7, 32'd2, 1'b0, q, r);
      chk("b2b2_q", 64'(q), 64'd3);
      chk("b2b2_r", 64'(r), 64'd1);

      for (int i = 0; i < 25; i++) begin
         sgn = 1'($urandom);
         a   = $urandom;
         case ($urandom_range(0, 7))
            0:       b = '0;
            1, 2:    b = W'($urandom_range(1, 20));
            3:       b = 32'hFFFFFFFF;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 9) == 0) a = 32'h80000000;
         run_div(sgn, a, b, 1'($urandom), q, r);
      end
      div_start = 1'b0;
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exe_div_unit.md
Name: exe_div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EXE stage. It serves OP_DIV and OP_DIVU.
- It consumes the forwarded operands (EXE_BusA/EXE_BusB after bypass) for the instruction in EXE.
- It stalls the front of the pipeline (PC, IF_ID, ID_EXE write enables) while iterating.
- It delivers quotient/remainder for the LO/HI write carried down via RegsWrType.HILOWr.

Parameters:
- DIV_WIDTH, 32: operand and result width. Iteration count equals DIV_WIDTH.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- div_start  in  1  EXE holds an OP_DIV/OP_DIVU; level, held while instruction sits in EXE.
- div_signed  in  1  1 = OP_DIV, 0 = OP_DIVU; sampled only when a start is accepted.
- div_opa  in  DIV_WIDTH  dividend (rs, post-bypass); sampled only when a start is accepted.
- div_opb  in  DIV_WIDTH  divisor (rt, post-bypass); sampled only when a start is accepted.
- div_cancel  in  1  EXEMEM_Flush / exception flush; aborts any operation.
- div_stall  out  1  to hazard unit; deasserts IF_PCWr, IF_IDWr and holds ID_EXE.
- div_busy  out  1  state is DIVIDE.
- div_valid  out  1  one-cycle pulse; result valid, EXE may advance.
- div_quotient  out  DIV_WIDTH  to LO.
- div_remainder  out  DIV_WIDTH  to HI.

Behaviour:
- States: IDLE, DIVIDE, DONE. An iteration counter of clog2(DIV_WIDTH)+1 bits holds the remaining steps.
- Reset (rst=0, async): state IDLE, counter 0. div_stall=0, div_busy=0, div_valid=0, div_quotient=0, div_remainder=0.
- IDLE:
  - A start is accepted when div_start=1 and div_cancel=0.
  - On acceptance, latch div_signed, sign(opa), sign(opb), |opa| and |opb|. Magnitudes use two's-complement negation only if div_signed and MSB=1.
  - Clear the partial remainder and load the counter with DIV_WIDTH.
  - If opb==0, go to DONE. Otherwise go to DIVIDE.
- DIVIDE, each cycle:
  - Shift {rem,quo} left by 1, bringing in the dividend MSB.
  - Compute trial = rem - |opb| at DIV_WIDTH+1 bits. If trial ≥ 0, rem = trial and quotient LSB = 1; else quotient LSB = 0.
  - Decrement the counter. When it reaches 0, go to DONE.
  - The divider is exactly DIV_WIDTH cycles in DIVIDE.
- DONE:
  - div_valid=1 for exactly one cycle, then go to IDLE unconditionally.
  - div_start is ignored in DONE, because the same instruction is still in EXE that cycle.
- Sign fix, applied when registering the outputs on entry to DONE:
  - quotient is negated if div_signed and sign(opa)≠sign(opb).
  - remainder is negated if div_signed and sign(opa)=1.
- Divide by zero: quotient = all ones, remainder = div_opa (raw dividend), independent of div_signed.
- Overflow case 0x80000000 / 0xFFFFFFFF with div_signed=1: quotient 0x80000000, remainder 0. No exception is raised.
- div_stall = (IDLE & div_start & ~div_cancel) | DIVIDE. It is 0 in DONE, so the instruction advances in the div_valid cycle.
- Latency: start accepted at cycle 0 gives div_valid at cycle DIV_WIDTH+1 (33). Divide by zero gives div_valid at cycle 1.
- div_quotient and div_remainder hold their last result until the next DONE. They are not cleared on return to IDLE.
- div_cancel:
  - In DIVIDE, next state is IDLE and no div_valid is produced.
  - In DONE, div_valid still pulses; the HILO write is suppressed downstream by the flush.
  - In IDLE, it blocks acceptance.
- Operand changes on div_opa/div_opb during DIVIDE have no effect.
- Back-to-back DIVs: the second is accepted in the first IDLE cycle after DONE.
- Reset mid-operation returns to IDLE immediately with all outputs at reset values.

Test Plan:
- DIVU 100/7, start at cycle 0 → div_stall 1 for cycles 0..32; div_valid at cycle 33; quotient 0x0000000E, remainder 0x00000002.
- DIV 0xFFFFFFF9 (-7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU with the same operands → quotient 0x7FFFFFFC, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 5/0 → div_valid at cycle 1, quotient 0xFFFFFFFF, remainder 0x00000005.
- Start DIVU 1000/3, assert div_cancel at cycle 10 → IDLE at cycle 11; no div_valid; div_stall 0 from cycle 11; outputs keep the previous result.
- Start a DIV, drive rst=0 asynchronously mid-cycle at cycle 15 → all outputs 0 immediately. After release, a new DIVU 9/3 → quotient 3, remainder 0 at +33.
- Two DIVUs back to back, 50/5 then 7/2 → first valid at cycle 33 (10, 0); second accepted at cycle 34, valid at cycle 67 (3, 1).
